leitor_tab_arquivos: RTL and testbench
======================================

# leitor_tab_arquivos

Sequential reader for the file table: on request, it reads a file's header word to get the length N, then copies the N payload words one per cycle into a destination memory. It is the read-side counterpart of the CPU-written file table, used by the OS loader path to move program files into instruction/data memory. It drives the table's address input and consumes its combinational read data, and drives a simple write-enable port toward the destination memory.

## Interface
- TAB_PROFUNDIDADE, 201: number of words in the file table (valid addresses 0..TAB_PROFUNDIDADE-1).
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request, sampled only in OCIOSO.
- enderecoBase  in  32  table address of the file header word; latched on accepted start.
- enderecoDestBase  in  32  first destination address; latched on accepted start.
- pausa  in  1  holds the copy when high; no write that cycle.
- enderecoTab  out  32  address driven to the file table read port.
- dadosTab  in  32  combinational read data from the file table at enderecoTab.
- enderecoDestino  out  32  destination write address.
- dadosDestino  out  32  destination write data.
- escreveDestino  out  1  destination write enable, one word per high cycle.
- ocupado  out  1  high in every state except OCIOSO.
- concluido  out  1  one-cycle pulse at end of every accepted request.
- erro  out  1  high from FIM until the next accepted start or reset; set when the file overruns the table.

## Operation
- Four states:
  - OCIOSO: ocupado=0, enderecoTab=0. iniciar=1 latches the base and destination addresses and moves to LE_CABECALHO.
  - LE_CABECALHO: enderecoTab=base. N is captured from dadosTab (full 32 bits).
    - N==0 → FIM, erro=0.
    - base+N > TAB_PROFUNDIDADE-1, computed in 33 bits so there is no wrap → FIM, erro=1, no writes.
    - Otherwise i=0 → COPIA.
- COPIA, each cycle:
  - enderecoTab=base+1+i; enderecoDestino=destBase+i; dadosDestino=dadosTab.
  - pausa=0: escreveDestino=1 and i increments; when i==N-1 on a write cycle → FIM.
  - pausa=1: escreveDestino=0 and i holds.
- FIM: concluido=1 for one cycle, ocupado=1 → OCIOSO.
- erro is cleared when a new start is accepted.
- iniciar is ignored while ocupado=1; there is no queuing.
- pausa is ignored outside COPIA.
- Destination address arithmetic is 32-bit modulo 2^32. Wrap is allowed and not flagged.

## Timing
- Reset (async assert, any state): state=OCIOSO, all outputs 0, erro=0, latched registers 0. Reset mid-copy aborts immediately: no further escreveDestino and no concluido.
- Start accepted on edge E0. LE_CABECALHO occupies cycle 1. COPIA occupies cycles 2..N+1 when there is no pausa. concluido is high in cycle N+2.
- Total latency is N+2 cycles plus one per paused COPIA cycle.
- N==0 or an overrun reaches concluido in cycle 2.
- Outputs are registered state decodes. enderecoTab and the destination outputs are valid throughout each state cycle. dadosDestino passes through combinationally from dadosTab.
- Back-to-back requests: iniciar high in the cycle after concluido is accepted. The minimum spacing is N+3 cycles between accepted starts.

## Test plan
- Table[10]=3, [11..13]=0xA,0xB,0xC; start base=10, dest=0x100 → writes (0x100,0xA),(0x101,0xB),(0x102,0xC) in cycles 2,3,4; concluido in cycle 5; erro=0.
- Table[20]=0; start → no escreveDestino; concluido in cycle 2; erro=0.
- Table[198]=5; start base=198 → no writes; concluido in cycle 2; erro=1. A following valid start clears erro.
- Same as the first test, but pausa=1 in cycle 3 → second write moves to cycle 4, third to cycle 5, concluido in cycle 6; destination addresses unchanged.
- Reset low in cycle 3 of a 3-word copy → outputs 0 immediately; only one write observed; no concluido. After release, iniciar is accepted normally.
- iniciar held high continuously over a 1-word file → starts accepted on cycles 0 and 4 only, with concluido in cycle 3 and cycle 7.

Source files
------------

// File: rtl/leitor_tab_arquivos_if.sv
// rtl/leitor_tab_arquivos_if.sv - request, file-table and destination signals of the file-table reader
interface leitor_tab_arquivos_if;
  logic        iniciar;
  logic [31:0] enderecoBase;
  logic [31:0] enderecoDestBase;
  logic        pausa;
  logic [31:0] enderecoTab;
  logic [31:0] dadosTab;
  logic [31:0] enderecoDestino;
  logic [31:0] dadosDestino;
  logic        escreveDestino;
  logic        ocupado;
  logic        concluido;
  logic        erro;

  modport master (
    input  iniciar, enderecoBase, enderecoDestBase, pausa, dadosTab,
    output enderecoTab, enderecoDestino, dadosDestino, escreveDestino,
           ocupado, concluido, erro
  );

  modport slave (
    output iniciar, enderecoBase, enderecoDestBase, pausa, dadosTab,
    input  enderecoTab, enderecoDestino, dadosDestino, escreveDestino,
           ocupado, concluido, erro
  );
endinterface

// File: rtl/leitor_tab_arquivos.sv
// rtl/leitor_tab_arquivos.sv - reads a file header length N and copies N payload words to a destination memory
module leitor_tab_arquivos #(
  parameter int TAB_PROFUNDIDADE = 201
) (
  input  logic                  clock,
  input  logic                  reset,
  leitor_tab_arquivos_if.master bus
);
  typedef enum logic [1:0] {OCIOSO, LE_CABECALHO, COPIA, FIM} estado_t;

  localparam logic [32:0] LP_TAB_ULTIMO = 33'(TAB_PROFUNDIDADE - 1);

  estado_t     r_estado;
  logic [31:0] r_base;
  logic [31:0] r_dest_base;
  logic [31:0] r_n;
  logic [31:0] r_i;
  logic [31:0] r_endereco_tab;
  logic [31:0] r_endereco_dest;
  logic        r_erro;

  logic [32:0] w_fim_arquivo;
  logic        w_copia;

  // Last payload address in 33 bits so a huge N cannot wrap past the check
  assign w_fim_arquivo = {1'b0, r_base} + {1'b0, bus.dadosTab};
  assign w_copia       = (r_estado == COPIA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado        <= OCIOSO;
      r_base          <= '0;
      r_dest_base     <= '0;
      r_n             <= '0;
      r_i             <= '0;
      r_endereco_tab  <= '0;
      r_endereco_dest <= '0;
      r_erro          <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            r_base         <= bus.enderecoBase;
            r_dest_base    <= bus.enderecoDestBase;
            r_endereco_tab <= bus.enderecoBase;
            r_erro         <= 1'b0;
            r_estado       <= LE_CABECALHO;
          end
        end
        LE_CABECALHO: begin
          r_n             <= bus.dadosTab;
          r_i             <= '0;
          r_endereco_dest <= r_dest_base;
          if (bus.dadosTab == 32'd0) begin
            r_endereco_tab <= '0;
            r_estado       <= FIM;
          end else if (w_fim_arquivo > LP_TAB_ULTIMO) begin
            r_erro         <= 1'b1;
            r_endereco_tab <= '0;
            r_estado       <= FIM;
          end else begin
            r_endereco_tab <= r_base + 32'd1;
            r_estado       <= COPIA;
          end
        end
        COPIA: begin
          if (!bus.pausa) begin
            if (r_i == r_n - 32'd1) begin
              r_endereco_tab <= '0;
              r_estado       <= FIM;
            end else begin
              r_i             <= r_i + 32'd1;
              r_endereco_tab  <= r_endereco_tab + 32'd1;
              r_endereco_dest <= r_endereco_dest + 32'd1;
            end
          end
        end
        FIM: begin
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  // Write strobe and data follow pausa/dadosTab in the same cycle
  assign bus.enderecoTab     = r_endereco_tab;
  assign bus.enderecoDestino = w_copia ? r_endereco_dest : 32'd0;
  assign bus.dadosDestino    = w_copia ? bus.dadosTab : 32'd0;
  assign bus.escreveDestino  = w_copia && !bus.pausa;
  assign bus.ocupado         = (r_estado != OCIOSO);
  assign bus.concluido       = (r_estado == FIM);
  assign bus.erro            = r_erro;
endmodule

// File: tb/tb_leitor_tab_arquivos.sv
// tb/tb_leitor_tab_arquivos.sv - directed self-checking bench for leitor_tab_arquivos
module tb_leitor_tab_arquivos;
  logic clock;
  logic reset;

  leitor_tab_arquivos_if bus ();

  leitor_tab_arquivos #(.TAB_PROFUNDIDADE(201)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0] tab [256];
  assign bus.dadosTab = (bus.enderecoTab < 32'd201) ? tab[bus.enderecoTab[7:0]] : 32'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          nw;
  int          w_cyc  [8];
  logic [31:0] w_addr [8];
  logic [31:0] w_data [8];
  int          conc_cyc;
  logic        erro_conc;
  logic        erro_c1;
  logic [31:0] rst_snap;

  task automatic run_req(input logic [31:0] base, input logic [31:0] dest,
                         input int pause_cyc, input int rst_cyc);
    @(negedge clock);
    bus.enderecoBase     = base;
    bus.enderecoDestBase = dest;
    bus.iniciar          = 1'b1;
    @(posedge clock);
    #1;
    bus.iniciar = 1'b0;
    nw          = 0;
    conc_cyc    = -1;
    erro_conc   = 1'b0;
    erro_c1     = 1'bx;
    rst_snap    = 32'hDEAD_BEEF;
    for (int c = 1; c <= 10; c++) begin
      reset     = (c == rst_cyc) ? 1'b0 : 1'b1;
      bus.pausa = (c == pause_cyc);
      @(negedge clock);
      if (c == rst_cyc)
        rst_snap = bus.enderecoTab | bus.enderecoDestino | bus.dadosDestino |
                   {28'd0, bus.escreveDestino, bus.ocupado, bus.concluido, bus.erro};
      if (c == 1) erro_c1 = bus.erro;
      if (bus.escreveDestino && nw < 8) begin
        w_cyc[nw]  = c;
        w_addr[nw] = bus.enderecoDestino;
        w_data[nw] = bus.dadosDestino;
        nw++;
      end
      if (bus.concluido && conc_cyc < 0) begin
        conc_cyc  = c;
        erro_conc = bus.erro;
      end
      @(posedge clock);
      #1;
    end
    reset     = 1'b1;
    bus.pausa = 1'b0;
  endtask

  task automatic chk_basic3(input string t);
    chk({t, "_nw"}, 32'(nw), 32'd3);
    chk({t, "_c0"}, 32'(w_cyc[0]), 32'd2);
    chk({t, "_a0"}, w_addr[0], 32'h100);
    chk({t, "_d0"}, w_data[0], 32'hA);
    chk({t, "_c1"}, 32'(w_cyc[1]), 32'd3);
    chk({t, "_a1"}, w_addr[1], 32'h101);
    chk({t, "_d1"}, w_data[1], 32'hB);
    chk({t, "_c2"}, 32'(w_cyc[2]), 32'd4);
    chk({t, "_a2"}, w_addr[2], 32'h102);
    chk({t, "_d2"}, w_data[2], 32'hC);
    chk({t, "_conc"}, 32'(conc_cyc), 32'd5);
    chk({t, "_erro"}, {31'd0, erro_conc}, 32'd0);
  endtask

  logic [8:0] occ_mask;
  logic [8:0] conc_mask;
  int         n6;

  initial begin
    for (int k = 0; k < 256; k++) tab[k] = 32'h1000 + 32'(k);
    tab[10] = 32'd3; tab[11] = 32'hA; tab[12] = 32'hB; tab[13] = 32'hC;
    tab[20] = 32'd0;
    tab[198] = 32'd5;
    tab[197] = 32'd3; tab[199] = 32'h77; tab[200] = 32'h88;
    tab[30] = 32'd1; tab[31] = 32'h55;

    reset                = 1'b0;
    bus.iniciar          = 1'b0;
    bus.pausa            = 1'b0;
    bus.enderecoBase     = 32'd0;
    bus.enderecoDestBase = 32'd0;
    repeat (2) @(negedge clock);
    chk("rst_ocupado", {31'd0, bus.ocupado}, 32'd0);
    chk("rst_concluido", {31'd0, bus.concluido}, 32'd0);
    chk("rst_erro", {31'd0, bus.erro}, 32'd0);
    chk("rst_escreve", {31'd0, bus.escreveDestino}, 32'd0);
    chk("rst_end_tab", bus.enderecoTab, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    run_req(32'd10, 32'h100, 0, 0);
    chk_basic3("t1");

    run_req(32'd20, 32'h300, 0, 0);
    chk("t2_nw", 32'(nw), 32'd0);
    chk("t2_conc", 32'(conc_cyc), 32'd2);
    chk("t2_erro", {31'd0, erro_conc}, 32'd0);

    run_req(32'd198, 32'h400, 0, 0);
    chk("t3_nw", 32'(nw), 32'd0);
    chk("t3_conc", 32'(conc_cyc), 32'd2);
    chk("t3_erro", {31'd0, erro_conc}, 32'd1);
    @(negedge clock);
    chk("t3_erro_held", {31'd0, bus.erro}, 32'd1);

    run_req(32'd10, 32'h100, 3, 0);
    chk("t4_erro_clr", {31'd0, erro_c1}, 32'd0);
    chk("t4_nw", 32'(nw), 32'd3);
    chk("t4_c0", 32'(w_cyc[0]), 32'd2);
    chk("t4_c1", 32'(w_cyc[1]), 32'd4);
    chk("t4_c2", 32'(w_cyc[2]), 32'd5);
    chk("t4_a1", w_addr[1], 32'h101);
    chk("t4_a2", w_addr[2], 32'h102);
    chk("t4_d2", w_data[2], 32'hC);
    chk("t4_conc", 32'(conc_cyc), 32'd6);

    run_req(32'd197, 32'hFFFF_FFFF, 0, 0);
    chk("t5_nw", 32'(nw), 32'd3);
    chk("t5_a0", w_addr[0], 32'hFFFF_FFFF);
    chk("t5_a1", w_addr[1], 32'h0);
    chk("t5_a2", w_addr[2], 32'h1);
    chk("t5_d0", w_data[0], 32'd5);
    chk("t5_d2", w_data[2], 32'h88);
    chk("t5_erro", {31'd0, erro_conc}, 32'd0);
    chk("t5_conc", 32'(conc_cyc), 32'd5);

    run_req(32'd10, 32'h100, 0, 3);
    chk("t6_rst_out", rst_snap, 32'd0);
    chk("t6_nw", 32'(nw), 32'd1);
    chk("t6_a0", w_addr[0], 32'h100);
    chk("t6_conc", 32'(conc_cyc), 32'hFFFF_FFFF);

    run_req(32'd10, 32'h100, 0, 0);
    chk_basic3("t7");

    @(negedge clock);
    bus.enderecoBase     = 32'd30;
    bus.enderecoDestBase = 32'h200;
    bus.iniciar          = 1'b1;
    occ_mask             = '0;
    conc_mask            = '0;
    n6                   = 0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clock);
      occ_mask[c]  = bus.ocupado;
      conc_mask[c] = bus.concluido;
      if (bus.escreveDestino) begin
        n6++;
        chk("t8_wdata", bus.dadosDestino, 32'h55);
      end
    end
    @(posedge clock);
    #1;
    bus.iniciar = 1'b0;
    chk("t8_conc_mask", {23'd0, conc_mask}, 32'h088);
    chk("t8_occ_mask", {23'd0, occ_mask}, 32'h0EE);
    chk("t8_writes", 32'(n6), 32'd2);
    repeat (6) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
